// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage has fixed priority, and MDU results wait in a FIFO.
// Also holds the MDU destination scoreboard. Optional counters are built under RF_WRITE_ARBITER_STATS_EN.
module rf_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_sel,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_sel,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_sel,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  output logic        hazard_stall,
  output logic        pipe_stall,
  output logic [31:0] busy_vec,
  output logic        writenable,
  output logic [4:0]  writesel,
  output logic [31:0] Din,
  output logic [31:0] stat_mdu_writes,
  output logic [31:0] stat_preempt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } mdu_ent_t;

  mdu_ent_t          fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  mdu_ent_t          head;
  logic              pipe_active;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic [31:0]       busy_nxt;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nxt;

  assign pipe_active = pipe_we && (pipe_sel != 5'd0);
  assign fifo_empty  = (count == CW'(0));
  assign fifo_full   = (count == CW'(DEPTH));
  assign head        = fifo_mem[rd_ptr];
  assign mdu_ready   = !fifo_full;
  assign pop         = !pipe_active && !fifo_empty;
  // Results addressed to r0 are acknowledged but never stored.
  assign push        = mdu_valid && mdu_ready && (mdu_sel != 5'd0);

  // Write port mux: pipeline first, then the FIFO head.
  always_comb begin
    writenable = 1'b0;
    writesel   = 5'd0;
    Din        = 32'd0;
    if (pipe_active) begin
      writenable = 1'b1;
      writesel   = pipe_sel;
      Din        = pipe_data;
    end else if (!fifo_empty) begin
      writenable = 1'b1;
      writesel   = head.sel;
      Din        = head.data;
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{sel: mdu_sel, data: mdu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Scoreboard update; a new issue overrides a retiring write to the same register.
  always_comb begin
    busy_nxt = busy_vec;
    if (pop) busy_nxt[head.sel] = 1'b0;
    if (issue_valid) busy_nxt[issue_sel] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= 32'd0;
    end else begin
      busy_vec <= busy_nxt;
    end
  end

  assign hazard_stall = busy_vec[rs1_sel] | busy_vec[rs2_sel];

  // Starvation counter: counts cycles the head is blocked by the pipeline.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || fifo_empty) begin
      starve_nxt = '0;
    end else if (pipe_active && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      pipe_stall <= (starve_nxt == SW'(STARVE_LIMIT));
    end
  end

`ifdef RF_WRITE_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_mdu_writes <= 32'd0;
      stat_preempt    <= 32'd0;
    end else begin
      if (pop) stat_mdu_writes <= stat_mdu_writes + 32'd1;
      if (pipe_active && !fifo_empty) stat_preempt <= stat_preempt + 32'd1;
    end
  end
`else
  assign stat_mdu_writes = 32'd0;
  assign stat_preempt    = 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model checked every cycle
// plus directed checks of the key scenarios.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_sel;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_sel;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_sel;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        hazard_stall;
  logic        pipe_stall;
  logic [31:0] busy_vec;
  logic        writenable;
  logic [4:0]  writesel;
  logic [31:0] Din;
  logic [31:0] stat_mdu_writes;
  logic [31:0] stat_preempt;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_sel(pipe_sel), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_sel(mdu_sel), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_sel(issue_sel),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .hazard_stall(hazard_stall), .pipe_stall(pipe_stall), .busy_vec(busy_vec),
    .writenable(writenable), .writesel(writesel), .Din(Din),
    .stat_mdu_writes(stat_mdu_writes), .stat_preempt(stat_preempt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_starve;
  int          m_pops;
  int          m_pre;
  bit          d_valid;
  bit          d_pa, d_pop, d_push, d_iss;
  logic [4:0]  d_iss_sel;
  ent_t        d_ent;
  bit          m_pa;
  logic        e_we;
  logic [4:0]  e_sel;
  logic [31:0] e_din;

  // Compare all outputs against the model mid-cycle and capture what the next edge does.
  always @(negedge clk) begin
    if (!rst) begin
      m_pa = pipe_we && (pipe_sel != 5'd0);
      if (m_pa) begin
        e_we = 1'b1; e_sel = pipe_sel; e_din = pipe_data;
      end else if (q.size() != 0) begin
        e_we = 1'b1; e_sel = q[0].sel; e_din = q[0].data;
      end else begin
        e_we = 1'b0; e_sel = 5'd0; e_din = 32'd0;
      end
      check("writenable", 32'(writenable), 32'(e_we));
      check("writesel", 32'(writesel), 32'(e_sel));
      check("Din", Din, e_din);
      check("mdu_ready", 32'(mdu_ready), 32'(q.size() < DEPTH));
      check("busy_vec", busy_vec, m_busy);
      check("hazard_stall", 32'(hazard_stall), 32'(m_busy[rs1_sel] | m_busy[rs2_sel]));
      check("pipe_stall", 32'(pipe_stall), 32'(m_starve == STARVE_LIMIT));
`ifdef RF_WRITE_ARBITER_STATS_EN
      check("stat_mdu_writes", stat_mdu_writes, 32'(m_pops));
      check("stat_preempt", stat_preempt, 32'(m_pre));
`else
      check("stat_mdu_writes", stat_mdu_writes, 32'd0);
      check("stat_preempt", stat_preempt, 32'd0);
`endif
      d_pa      = m_pa;
      d_pop     = !m_pa && (q.size() != 0);
      d_push    = mdu_valid && (q.size() < DEPTH) && (mdu_sel != 5'd0);
      d_ent     = '{sel: mdu_sel, data: mdu_data};
      d_iss     = issue_valid;
      d_iss_sel = issue_sel;
      d_valid   = 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_busy   = 32'd0;
      m_starve = 0;
      m_pops   = 0;
      m_pre    = 0;
      d_valid  = 1'b0;
    end else if (d_valid) begin
      if (d_pop || q.size() == 0) m_starve = 0;
      else if (d_pa && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
      if (d_pa && q.size() != 0) m_pre = m_pre + 1;
      if (d_pop) begin
        m_busy[q[0].sel] = 1'b0;
        m_pops = m_pops + 1;
        void'(q.pop_front());
      end
      if (d_iss) m_busy[d_iss_sel] = 1'b1;
      m_busy[0] = 1'b0;
      if (d_push) q.push_back(d_ent);
      d_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_sel = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_sel = 5'd0; mdu_data = 32'd0;
    issue_valid = 1'b0; issue_sel = 5'd0;
    rs1_sel = 5'd0; rs2_sel = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) tick();
    check("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check("rst_busy_vec", busy_vec, 32'd0);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check("rst_writenable", 32'(writenable), 32'd0);
    rst = 1'b0;

    // Pipeline write goes straight through in the same cycle.
    pipe_we = 1'b1; pipe_sel = 5'd5; pipe_data = 32'hDEADBEEF;
    #2;
    check("pipe_we", 32'(writenable), 32'd1);
    check("pipe_sel", 32'(writesel), 32'd5);
    check("pipe_din", Din, 32'hDEADBEEF);
    tick();

    // One queued MDU entry drains while the pipe writes r0.
    idle(); issue_valid = 1'b1; issue_sel = 5'd7;
    tick();
    idle(); mdu_valid = 1'b1; mdu_sel = 5'd7; mdu_data = 32'h11;
    #2;
    check("accept_no_write", 32'(writenable), 32'd0);
    tick();
    idle(); pipe_we = 1'b1; pipe_sel = 5'd0; pipe_data = 32'hFFFF_FFFF;
    #2;
    check("r0_head_we", 32'(writenable), 32'd1);
    check("r0_head_sel", 32'(writesel), 32'd7);
    check("r0_head_din", Din, 32'h11);
    check("busy7_set", 32'(busy_vec[7]), 32'd1);
    tick();
    idle();
    check("busy7_clear", 32'(busy_vec[7]), 32'd0);
    check("empty_we", 32'(writenable), 32'd0);

    // Hazard on r9 until its result retires.
    issue_valid = 1'b1; issue_sel = 5'd9; rs1_sel = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("hazard_set", 32'(hazard_stall), 32'd1);
    mdu_valid = 1'b1; mdu_sel = 5'd9; mdu_data = 32'h99;
    pipe_we = 1'b1; pipe_sel = 5'd2; pipe_data = 32'h22;
    tick();
    mdu_valid = 1'b0;
    tick();
    check("hazard_held", 32'(hazard_stall), 32'd1);
    pipe_we = 1'b0;
    tick();
    check("hazard_clear", 32'(hazard_stall), 32'd0);
    idle();
    tick();

    // Fill the FIFO under continuous pipe traffic until starvation saturates.
    for (int i = 0; i < 12; i++) begin
      pipe_we = 1'b1; pipe_sel = 5'd12; pipe_data = 32'(i);
      mdu_valid = (i < 4);
      mdu_sel   = 5'(13 + i);
      mdu_data  = 32'h100 + 32'(i);
      tick();
    end
    idle();
    check("full_ready", 32'(mdu_ready), 32'd0);
    check("starve_stall", 32'(pipe_stall), 32'd1);
    #2;
    check("bubble_sel", 32'(writesel), 32'd13);
    check("bubble_din", Din, 32'h100);
    tick();
    check("stall_release", 32'(pipe_stall), 32'd0);
    check("ready_release", 32'(mdu_ready), 32'd1);
    repeat (4) tick();

    // Asynchronous reset with three results queued.
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_sel = 5'd20; pipe_data = 32'(i);
      issue_valid = 1'b1;
      issue_sel = (i == 0) ? 5'd3 : ((i == 1) ? 5'd4 : 5'd6);
      mdu_valid = 1'b1; mdu_sel = issue_sel; mdu_data = 32'h300 + 32'(i);
      tick();
    end
    issue_valid = 1'b0; mdu_valid = 1'b0;
    check("pre_rst_busy", busy_vec, 32'h0000_0058);
    @(posedge clk);
    #3;
    idle();
    rst = 1'b1;
    #1;
    check("arst_busy", busy_vec, 32'd0);
    check("arst_ready", 32'(mdu_ready), 32'd1);
    check("arst_stall", 32'(pipe_stall), 32'd0);
    check("arst_we", 32'(writenable), 32'd0);
    tick();
    rst = 1'b0;

    // Statistics: three pops, two preempted cycles.
    mdu_valid = 1'b1; mdu_sel = 5'd1; mdu_data = 32'hA1;
    tick();
    mdu_sel = 5'd2; mdu_data = 32'hA2;
    pipe_we = 1'b1; pipe_sel = 5'd10; pipe_data = 32'hB0;
    tick();
    mdu_sel = 5'd3; mdu_data = 32'hA3;
    pipe_sel = 5'd11; pipe_data = 32'hB1;
    tick();
    idle();
    repeat (5) tick();
`ifdef RF_WRITE_ARBITER_STATS_EN
    check("stat_writes_final", stat_mdu_writes, 32'd3);
    check("stat_preempt_final", stat_preempt, 32'd2);
`else
    check("stat_writes_final", stat_mdu_writes, 32'd0);
    check("stat_preempt_final", stat_preempt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
